// File: rtl/clock_buffer_pkg.sv
// Shared definitions for the clock divider bank.
// Holds the per-channel state encoding and the default bank geometry.
package clock_buffer_pkg;

    // Default bank geometry
    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned DIV_W_DEF  = 8;

    // Channel phase: parked, driving the high half, driving the low half
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/clock_div_channel.sv
// One glitch-free programmable divider channel.
// Ports:
//   clk_in     source clock, rising edge
//   rst_in     synchronous active-high reset
//   div_in     half-period code D
//   load_in    capture div_in into the pending code
//   en_in      run enable (sampled only in idle and at the end of a period)
//   clk_out    registered divided clock, period 2*(D+1)
//   tick_out   one-cycle pulse in the rising cycle of clk_out
//   active_out high while the channel is not idle
module clock_div_channel
    import clock_buffer_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [DIV_W-1:0] div_in,
    input  logic             load_in,
    input  logic             en_in,
    output logic             clk_out,
    output logic             tick_out,
    output logic             active_out
);

    localparam logic [DIV_W-1:0] DefCode = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] One     = {{(DIV_W-1){1'b0}}, 1'b1};

    ch_state_e        r_state, w_state_d;
    logic [DIV_W-1:0] r_cnt, w_cnt_d;
    logic [DIV_W-1:0] r_hp, w_hp_d;
    logic [DIV_W-1:0] r_pend, w_pend_d;
    logic             r_clk, w_clk_d;
    logic             r_tick, w_tick_d;
    logic [DIV_W-1:0] w_code;
    logic             w_cnt_end;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_hp    <= DefCode;
            r_pend  <= DefCode;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_hp    <= w_hp_d;
            r_pend  <= w_pend_d;
            r_clk   <= w_clk_d;
            r_tick  <= w_tick_d;
        end
    end

    // Next-state logic
    always_comb begin
        // A load in the same cycle as HIGH entry bypasses the pending register
        w_code    = load_in ? div_in : r_pend;
        w_cnt_end = (r_cnt == r_hp);
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_hp_d    = r_hp;
        w_pend_d  = w_code;
        w_clk_d   = r_clk;
        w_tick_d  = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                w_clk_d = 1'b0;
                if (en_in) begin
                    w_state_d = StHigh;
                    w_hp_d    = w_code;
                    w_clk_d   = 1'b1;
                    w_tick_d  = 1'b1;
                end
            end
            StHigh: begin
                if (w_cnt_end) begin
                    w_state_d = StLow;
                    w_cnt_d   = '0;
                    w_clk_d   = 1'b0;
                end else begin
                    w_cnt_d = r_cnt + One;
                end
            end
            StLow: begin
                if (w_cnt_end) begin
                    // hp only changes here, at a period boundary, so phases never shorten
                    w_cnt_d = '0;
                    if (en_in) begin
                        w_state_d = StHigh;
                        w_hp_d    = w_code;
                        w_clk_d   = 1'b1;
                        w_tick_d  = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                        w_clk_d   = 1'b0;
                    end
                end else begin
                    w_cnt_d = r_cnt + One;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_clk_d   = 1'b0;
            end
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        clk_out    = r_clk;
        tick_out   = r_tick;
        active_out = (r_state != StIdle);
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent glitch-free clock dividers sharing one source clock.
// Ports:
//   clk_in     source clock, rising edge
//   rst_in     synchronous active-high reset
//   div_in     per-channel half-period codes, channel i at [i*DIV_W +: DIV_W]
//   load_in    per-channel pending-code load strobes
//   en_in      per-channel run enables
//   clk_out    per-channel divided clocks
//   tick_out   per-channel rising-cycle strobes
//   active_out per-channel busy flags
module clock_divider_bank
    import clock_buffer_pkg::*;
#(
    parameter int unsigned NUM_CH      = NUM_CH_DEF,
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = 0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_CH*DIV_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       load_in,
    input  logic [NUM_CH-1:0]       en_in,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick_out,
    output logic [NUM_CH-1:0]       active_out
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clock_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .div_in     (div_in[g*DIV_W +: DIV_W]),
            .load_in    (load_in[g]),
            .en_in      (en_in[g]),
            .clk_out    (clk_out[g]),
            .tick_out   (tick_out[g]),
            .active_out (active_out[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

    localparam int NUM_CH      = 4;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 0;

    logic                    clk_in;
    logic                    rst_in;
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH-1:0]       load_in;
    logic [NUM_CH-1:0]       en_in;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick_out;
    logic [NUM_CH-1:0]       active_out;

    int n_chk = 0;
    int n_err = 0;

    clock_divider_bank #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .div_in     (div_in),
        .load_in    (load_in),
        .en_in      (en_in),
        .clk_out    (clk_out),
        .tick_out   (tick_out),
        .active_out (active_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural model: each running channel is a position within a period of
    // 2*(hp+1) cycles; the first hp+1 positions are high.
    bit m_run  [NUM_CH];
    int m_pos  [NUM_CH];
    int m_hp   [NUM_CH];
    int m_pend [NUM_CH];
    bit chk_on = 1'b0;

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_run[c] = 1'b0; m_pos[c] = 0; m_hp[c] = DEFAULT_DIV; m_pend[c] = DEFAULT_DIV;
        end
    end

    always @(posedge clk_in) begin
        if (rst_in) chk_on = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            int slice;
            int code;
            slice = int'(div_in[c*DIV_W +: DIV_W]);
            code  = load_in[c] ? slice : m_pend[c];
            if (rst_in) begin
                m_run[c] = 1'b0; m_pos[c] = 0; m_hp[c] = DEFAULT_DIV; m_pend[c] = DEFAULT_DIV;
            end else begin
                if (!m_run[c]) begin
                    if (en_in[c]) begin
                        m_run[c] = 1'b1; m_pos[c] = 0; m_hp[c] = code;
                    end
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                    if (m_pos[c] == 2 * (m_hp[c] + 1)) begin
                        if (en_in[c]) begin
                            m_pos[c] = 0; m_hp[c] = code;
                        end else begin
                            m_run[c] = 1'b0; m_pos[c] = 0;
                        end
                    end
                end
                if (load_in[c]) m_pend[c] = slice;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_in) begin
        if (chk_on) begin
            logic [NUM_CH-1:0] e_clk, e_tick, e_act;
            for (int c = 0; c < NUM_CH; c++) begin
                e_act[c]  = m_run[c];
                e_clk[c]  = m_run[c] && (m_pos[c] <= m_hp[c]);
                e_tick[c] = m_run[c] && (m_pos[c] == 0);
            end
            n_chk += 3;
            if (clk_out !== e_clk) begin
                n_err++;
                $display("FAIL model clk_out t=%0t got=%b exp=%b", $time, clk_out, e_clk);
            end
            if (tick_out !== e_tick) begin
                n_err++;
                $display("FAIL model tick_out t=%0t got=%b exp=%b", $time, tick_out, e_tick);
            end
            if (active_out !== e_act) begin
                n_err++;
                $display("FAIL model active_out t=%0t got=%b exp=%b", $time, active_out, e_act);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic cycle(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    logic [31:0] v0, v1, v2, v3, t0;

    initial begin
        rst_in = 1'b1; en_in = '0; load_in = '0; div_in = '0;
        #2;

        // Reset with random enables and loads
        for (int i = 0; i < 2; i++) begin
            en_in   = NUM_CH'($urandom);
            load_in = NUM_CH'($urandom);
            div_in  = $urandom;
            cycle();
        end
        check("reset clk_out", 32'(clk_out), 32'h0);
        check("reset tick_out", 32'(tick_out), 32'h0);
        check("reset active_out", 32'(active_out), 32'h0);

        // Release with default D=0: clk_in/2
        rst_in = 1'b0; en_in = '1; load_in = '0; div_in = '0;
        v0 = '0; t0 = '0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            v0 = {v0[30:0], clk_out[0]};
            t0 = {t0[30:0], tick_out[0]};
        end
        check("default div clk", v0, 32'b101010);
        check("default div tick", t0, 32'b101010);
        en_in = '0;
        cycle(10);

        // Ratio D=2 on ch0
        div_in = 32'h0000_0002; load_in = 4'b0001;
        cycle();
        load_in = '0; en_in = 4'b0001;
        v0 = '0; t0 = '0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            v0 = {v0[30:0], clk_out[0]};
            t0 = {t0[30:0], tick_out[0]};
        end
        check("ratio D=2 clk", v0, 32'b111000111000);
        check("ratio D=2 tick", t0, 32'b100000100000);
        en_in = '0;
        cycle(16);

        // Glitch-free change on ch1: D=4 running, load D=1 at cnt=2 of HIGH
        div_in = 32'h0000_0400; load_in = 4'b0010; en_in = 4'b0010;
        v1 = '0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            v1 = {v1[30:0], clk_out[1]};
            load_in = '0;
            if (i == 2) begin
                div_in = 32'h0000_0100; load_in = 4'b0010;
            end
        end
        check("ratio change clk", v1, 32'b1111100000110011);
        en_in = '0;
        cycle(30);

        // Stop/start on ch2, D=3, enable dropped at cnt=1 of HIGH
        div_in = 32'h0003_0000; load_in = 4'b0100; en_in = 4'b0100;
        v2 = '0; t0 = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            v2 = {v2[30:0], clk_out[2]};
            t0 = {t0[30:0], active_out[2]};
            load_in = '0;
            if (i == 1) en_in = '0;
        end
        check("stop clk", v2, 32'b1111000000);
        check("stop active", t0, 32'b1111111100);
        en_in = 4'b0100;
        cycle();
        check("restart clk", 32'(clk_out[2]), 32'h1);
        check("restart tick", 32'(tick_out[2]), 32'h1);

        // Reset mid-period on ch3, D=5
        div_in = 32'h0500_0000; load_in = 4'b1000; en_in = 4'b1000;
        cycle();
        load_in = '0;
        cycle();
        rst_in = 1'b1;
        cycle();
        check("midrst clk_out", 32'(clk_out), 32'h0);
        check("midrst active_out", 32'(active_out), 32'h0);
        rst_in = 1'b0;
        v3 = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            v3 = {v3[30:0], clk_out[3]};
        end
        check("post-reset default clk", v3, 32'b1010);
        en_in = '0;
        cycle(30);

        // Independence: D=0,1,2,3 started together, later reload ch0 to D=3
        div_in = 32'h0302_0100; load_in = '1; en_in = '1;
        v0 = '0; v1 = '0; v2 = '0; v3 = '0; t0 = '0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            v0 = {v0[30:0], clk_out[0]};
            v1 = {v1[30:0], clk_out[1]};
            v2 = {v2[30:0], clk_out[2]};
            v3 = {v3[30:0], clk_out[3]};
            t0 = {t0[30:0], tick_out[3]};
            load_in = '0;
            if (i == 3) begin
                div_in = 32'h0302_0103; load_in = 4'b0001;
            end
        end
        check("indep ch0", v0, 32'b101011110000);
        check("indep ch1", v1, 32'b110011001100);
        check("indep ch2", v2, 32'b111000111000);
        check("indep ch3", v3, 32'b111100001111);
        check("indep ch3 tick", t0, 32'b100000001000);
        en_in = '0;
        cycle(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
